// File: rtl/ula_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer.
// Holds the slice width, FSM state encoding and common select codes.
package ula_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] S_ADD = 4'b0001;
  localparam logic [3:0] S_SUB = 4'b0010;
  localparam logic [3:0] S_XOR = 4'b0110;

endpackage

// File: rtl/ula_nibble_sequencer.sv
// Feeds a W-bit ALU operation through a 4-bit slice, LSB nibble first.
// Carry and A=B are chained in registers; results are collected per nibble.
module ula_nibble_sequencer
  import ula_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  in_b,
  input  logic [3:0]                   in_s,
  input  logic                         in_m,
  input  logic                         in_cin,
  output logic [3:0]                   alu_a,
  output logic [3:0]                   alu_b,
  output logic [3:0]                   alu_s,
  output logic                         alu_m,
  output logic                         alu_cin,
  input  logic [3:0]                   alu_f,
  input  logic                         alu_cout,
  input  logic                         alu_eq,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  res_f,
  output logic                         res_cout,
  output logic                         res_eq,
  output logic                         res_zero,
  output logic                         busy
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] nib_vec_t;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  nib_vec_t      a_q, a_d;
  nib_vec_t      b_q, b_d;
  logic [3:0]    s_q, s_d;
  logic          m_q, m_d;
  logic          cin_q, cin_d;
  logic          carry_q, carry_d;
  logic          eq_q, eq_d;
  nib_vec_t      f_q, f_d;
  logic          cout_q, cout_d;
  logic          reseq_q, reseq_d;
  logic          zero_q, zero_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    eq_d    = eq_q;
    f_d     = f_q;
    cout_d  = cout_q;
    reseq_d = reseq_q;
    zero_d  = zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          s_d     = in_s;
          m_d     = in_m;
          cin_d   = in_cin;
          carry_d = in_cin;
          eq_d    = 1'b1;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        f_d[idx_q] = alu_f;
        carry_d    = alu_cout;
        eq_d       = eq_q & alu_eq;
        if (idx_q == LAST) begin
          // idx parks at 0 so the slice sees nibble 0 while idle
          idx_d   = '0;
          cout_d  = alu_cout;
          reseq_d = eq_q & alu_eq;
          zero_d  = (f_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      reseq_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      eq_q    <= eq_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      reseq_q <= reseq_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

  assign alu_a   = a_q[idx_q];
  assign alu_b   = b_q[idx_q];
  assign alu_s   = s_q;
  assign alu_m   = m_q;
  assign alu_cin = (state_q == ST_RUN) ? carry_q : cin_q;

  assign res_f    = f_q;
  assign res_cout = cout_q;
  assign res_eq   = reseq_q;
  assign res_zero = zero_q;

endmodule

// File: tb/tb_ula_nibble_sequencer.sv
// Directed bench for the nibble sequencer driving a behavioural 4-bit slice.
// Vector table plus hand-written backpressure and reset sequences.
module tb_ula_nibble_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic [3:0]   in_s;
  logic         in_m, in_cin;
  logic [3:0]   alu_a, alu_b, alu_s, alu_f;
  logic         alu_m, alu_cin, alu_cout, alu_eq;
  logic         out_valid, out_ready;
  logic [W-1:0] res_f;
  logic         res_cout, res_eq, res_zero, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ula_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_m(in_m), .in_cin(in_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
    .alu_cin(alu_cin), .alu_f(alu_f), .alu_cout(alu_cout), .alu_eq(alu_eq),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_f(res_f), .res_cout(res_cout), .res_eq(res_eq),
    .res_zero(res_zero), .busy(busy)
  );

  // Behavioural stand-in for the 4-bit slice: add, subtract, xor, not.
  always_comb begin
    logic [4:0] sum;
    sum = 5'd0;
    if (alu_m) begin
      case (alu_s)
        4'b0110: sum = {1'b0, alu_a ^ alu_b};
        4'b0000: sum = {1'b0, ~alu_a};
        default: sum = {1'b0, alu_a & alu_b};
      endcase
    end else begin
      case (alu_s)
        4'b0001: sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
        4'b0010: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
        default: sum = {1'b0, alu_a} + {4'd0, alu_cin};
      endcase
    end
    alu_f    = sum[3:0];
    alu_cout = alu_m ? 1'b0 : sum[4];
    alu_eq   = (alu_a == alu_b);
  end

  typedef struct {
    string        name;
    logic         m;
    logic [3:0]   s;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] f;
    logic         cout;
    logic         eq;
    logic         zero;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic start_op(input vec_t v);
    chk({v.name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_a = v.a; in_b = v.b; in_s = v.s; in_m = v.m; in_cin = v.cin;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, 32'd4);
  endtask

  task automatic check_res(input vec_t v);
    chk({v.name, " res_f"}, {16'd0, res_f}, {16'd0, v.f});
    chk({v.name, " res_cout"}, {31'd0, res_cout}, {31'd0, v.cout});
    chk({v.name, " res_eq"}, {31'd0, res_eq}, {31'd0, v.eq});
    chk({v.name, " res_zero"}, {31'd0, res_zero}, {31'd0, v.zero});
  endtask

  task automatic finish_op(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " out_valid after accept"}, {31'd0, out_valid}, 32'd0);
    chk({nm, " in_ready after accept"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{"add", 1'b0, 4'b0001, 1'b0, 16'h1234, 16'h0FFF,
                16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"ovf", 1'b0, 4'b0001, 1'b0, 16'hFFFF, 16'h0001,
                16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{"sub", 1'b0, 4'b0010, 1'b1, 16'h1000, 16'h0001,
                16'h0FFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"xor", 1'b1, 4'b0110, 1'b0, 16'hA5A5, 16'hFFFF,
                16'h5A5A, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"xoreq", 1'b1, 4'b0110, 1'b0, 16'hBEEF, 16'hBEEF,
                16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{"addc", 1'b0, 4'b0001, 1'b1, 16'h00FF, 16'h0001,
                16'h0101, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_s = '0; in_m = 1'b0; in_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst res_f", {16'd0, res_f}, 32'd0);
    chk("rst flags", {29'd0, res_cout, res_eq, res_zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i]);
      chk({vecs[i].name, " busy"}, {31'd0, busy}, 32'd1);
      wait_done(vecs[i].name);
      check_res(vecs[i]);
      finish_op(vecs[i].name);
    end

    // Backpressure: hold result while a competing request is offered
    start_op(vecs[0]);
    wait_done("bp");
    in_a = 16'h5555; in_b = 16'h1111; in_s = 4'b0010; in_m = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
      check_res(vecs[0]);
    end
    in_valid = 1'b0;
    finish_op("bp");
    chk("bp busy idle", {31'd0, busy}, 32'd0);

    // Reset in the second RUN cycle, then a clean operation
    start_op(vecs[1]);
    @(posedge clk); #1;
    chk("mid busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst mid out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst mid busy", {31'd0, busy}, 32'd0);
    chk("rst mid in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rel in_ready", {31'd0, in_ready}, 32'd1);
    start_op(vecs[0]);
    wait_done("after rst");
    check_res(vecs[0]);
    finish_op("after rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
